// File: rtl/dom_and_pipe.sv
// Two-stage DOM-indep masked AND / sharewise XOR over N shares of W bits,
// with elastic valid/ready handshakes on operands, randomness and result.
module dom_and_pipe #(
    parameter int unsigned D = 2,
    parameter int unsigned N = D + 1,
    parameter int unsigned W = 32,
    parameter int unsigned L = N * D / 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_op,
    input  logic [N*W-1:0] port_a,
    input  logic [N*W-1:0] port_b,
    input  logic           rnd_valid,
    output logic           rnd_ready,
    input  logic [L*W-1:0] port_r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] port_c,
    output logic           busy
);
    localparam int unsigned PW = N * N * W;

    logic           s1_v;
    logic           s2_v;
    logic           s1_en;
    logic           s2_en;
    logic           acc;
    logic [PW-1:0]  pp_d;
    logic [PW-1:0]  pp_q;
    logic [N*W-1:0] c_d;
    logic [N*W-1:0] c_q;

    // Randomness slot shared by the unordered share pair {i, j}, i != j.
    function automatic int unsigned pair_slot(int unsigned i, int unsigned j);
        int unsigned lo;
        int unsigned hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo + (hi * (hi - 1)) / 2;
    endfunction

    assign s2_en     = !s2_v || out_ready;
    assign s1_en     = !s1_v || s2_en;
    assign in_ready  = s1_en && (in_op || rnd_valid);
    assign acc       = in_valid && in_ready && !rst;
    assign rnd_ready = acc && !in_op;
    assign out_valid = s2_v;
    assign port_c    = c_q;
    assign busy      = s1_v || s2_v;

    // Partial products; cross terms are blinded by the pair's fresh mask.
    always_comb begin
        pp_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (i == j) begin
                    if (in_op) begin
                        pp_d[(i*N+j)*W +: W] = port_a[i*W +: W] ^ port_b[i*W +: W];
                    end else begin
                        pp_d[(i*N+j)*W +: W] = port_a[i*W +: W] & port_b[i*W +: W];
                    end
                end else if (!in_op) begin
                    pp_d[(i*N+j)*W +: W] = (port_a[i*W +: W] & port_b[j*W +: W])
                                         ^ port_r[pair_slot(i, j)*W +: W];
                end
            end
        end
    end

    // Share compression only ever reads registered partial products.
    always_comb begin
        c_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                c_d[i*W +: W] = c_d[i*W +: W] ^ pp_q[(i*N+j)*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            pp_q <= '0;
            c_q  <= '0;
        end else begin
            if (s1_en) begin
                s1_v <= acc;
                if (acc) begin
                    pp_q <= pp_d;
                end
            end
            if (s2_en) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    c_q <= c_d;
                end
            end
        end
    end
endmodule
